// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sends SYNC_CODE then a latched payload, both LSB first,
// one bit per clock, with registered data/data_valid/busy/done.
module sync_frame_tx #(
  parameter int                    SYNC_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [SYNC_WIDTH-1:0] SYNC_CODE  = 4'b1001
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] payload,
  output logic                  data,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int MAXW = (SYNC_WIDTH > DATA_WIDTH) ? SYNC_WIDTH : DATA_WIDTH;
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD, DONE} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [DATA_WIDTH-1:0]   sh, sh_n;
  logic [SYNC_WIDTH-1:0]   sync_rest;
  logic                    data_n, valid_n, done_n;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sh         <= '0;
      data       <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sh         <= sh_n;
      data       <= data_n;
      data_valid <= valid_n;
      busy       <= valid_n;
      done       <= done_n;
    end
  end

  // Outputs are computed for the state being entered, so each bit appears
  // the cycle after the decision that selects it.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sh_n      = sh;
    data_n    = 1'b0;
    valid_n   = 1'b0;
    done_n    = 1'b0;
    sync_rest = SYNC_CODE >> (cnt + 1'b1);
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SYNC;
          cnt_n   = '0;
          sh_n    = payload;
          data_n  = SYNC_CODE[0];
          valid_n = 1'b1;
        end
      end
      SYNC: begin
        valid_n = 1'b1;
        if (cnt == SYNC_LAST) begin
          state_n = PAYLOAD;
          cnt_n   = '0;
          data_n  = sh[0];
        end else begin
          cnt_n  = cnt + 1'b1;
          data_n = sync_rest[0];
        end
      end
      PAYLOAD: begin
        if (cnt == DATA_LAST) begin
          state_n = DONE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n   = cnt + 1'b1;
          sh_n    = sh >> 1;
          data_n  = sh_n[0];
          valid_n = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx: frame contents, latency, gaps, ignored starts,
// asynchronous reset mid-frame and a loopback sync detector.
module tb_sync_frame_tx;

  logic       clk = 1'b0;
  logic       Reset;
  logic       start;
  logic [7:0] payload;
  logic       data, data_valid, busy, done;

  int tests = 0;
  int fails = 0;

  sync_frame_tx #(.SYNC_WIDTH(4), .DATA_WIDTH(8), .SYNC_CODE(4'b1001)) dut (
    .clk(clk), .Reset(Reset), .start(start), .payload(payload),
    .data(data), .data_valid(data_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Loopback receiver: shifts in valid bits (newest at MSB) and flags a sync match
  // one cycle after the shift that completed it.
  logic [3:0] det_sh;
  logic       det_shifted, det;
  always @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      det_sh <= 4'b0; det_shifted <= 1'b0; det <= 1'b0;
    end else begin
      if (data_valid) det_sh <= {data, det_sh[3:1]};
      det_shifted <= data_valid;
      det <= det_shifted && (det_sh == 4'b1001);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for data_valid; n is the number of negedges waited.
  task automatic wait_valid(output int n);
    n = 0;
    while (data_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Called at the negedge showing the first bit; collects 12 bits, pulsing start
  // per the mask, checks busy tracks valid, and ends on the done cycle.
  task automatic run_frame(input string tag, input logic [11:0] exp_bits,
                           input logic [11:0] start_mask);
    logic [11:0] bits;
    int nvalid, nbad;
    bits = '0; nvalid = 0; nbad = 0;
    for (int i = 0; i < 12; i++) begin
      bits = {bits[10:0], data};
      if (data_valid === 1'b1) nvalid++;
      if (busy !== data_valid || done !== 1'b0) nbad++;
      start = start_mask[11-i];
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_bits"}, {20'd0, bits}, {20'd0, exp_bits});
    chk({tag, "_nvalid"}, nvalid, 12);
    chk({tag, "_busy_eq_valid"}, nbad, 0);
    chk({tag, "_done_cycle"}, {data, data_valid, busy, done}, 4'b0001);
  endtask

  int n, quiet, det_cnt, det_at0, det_at1;

  initial begin
    Reset = 1'b0; start = 1'b0; payload = 8'h00;
    #3;
    chk("reset_outs", {data, data_valid, busy, done}, 4'b0000);
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    chk("idle_outs", {data, data_valid, busy, done}, 4'b0000);

    // Single frame A5, one-cycle latency, done pulses once
    payload = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("a5_latency", {data_valid, busy, data}, 3'b111);
    run_frame("a5", 12'b1001_1010_0101, 12'b0);
    @(negedge clk);
    chk("a5_done_one_cycle", {data_valid, done}, 2'b00);

    // start held high: frames back to back with a 2-cycle gap
    @(negedge clk);
    payload = 8'h3C; start = 1'b1;
    @(negedge clk);
    payload = 8'hFF;
    run_frame("b2b_3c", 12'b1001_0011_1100, 12'hFFF);
    start = 1'b1;
    wait_valid(n);
    chk("b2b_gap", n, 2);
    payload = 8'h11;
    run_frame("b2b_ff", 12'b1001_1111_1111, 12'b0);

    // start pulses at frame cycles 3 and 8 are ignored
    repeat (3) @(negedge clk);
    payload = 8'h96; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_frame("ign", 12'b1001_0110_1001, 12'b0001_0000_1000);
    quiet = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (data_valid !== 1'b0 || done !== 1'b0) quiet++;
    end
    chk("ign_no_second_frame", quiet, 0);

    // Asynchronous reset during payload bit 4
    payload = 8'hC3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_mid_pre", {data_valid, busy}, 2'b11);
    #1 Reset = 1'b0;
    #1;
    chk("rst_mid_async", {data, data_valid, busy, done}, 4'b0000);
    @(negedge clk);
    Reset = 1'b1;
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (data_valid !== 1'b0 || done !== 1'b0) quiet++;
    end
    chk("rst_no_resume", quiet, 0);
    payload = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_frame("rst_new", 12'b1001_1010_0101, 12'b0);

    // Loopback with payload 00: one detect per frame, 2 cycles after sync bit 3
    @(negedge clk);
    payload = 8'h00; start = 1'b1;
    @(negedge clk);
    det_cnt = 0; det_at0 = -1; det_at1 = -1;
    for (int i = 0; i < 30; i++) begin
      if (i == 14) start = 1'b0;
      if (det === 1'b1) begin
        if (det_cnt == 0) det_at0 = i; else det_at1 = i;
        det_cnt++;
      end
      @(negedge clk);
    end
    chk("loop_det_count", det_cnt, 2);
    chk("loop_det_pos0", det_at0, 5);
    chk("loop_det_pos1", det_at1, 19);

    // Payload change after accept does not affect the frame
    payload = 8'h81; start = 1'b1;
    @(negedge clk);
    start = 1'b0; payload = 8'h7E;
    wait_valid(n);
    chk("late_payload_latency", n, 0);
    run_frame("late_payload", 12'b1001_1000_0001, 12'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
